ula_multiciclo: RTL and testbench
=================================

# ula_multiciclo

Parametrised, registered ALU for the processor datapath, the successor to the 8-bit combinational ALU. It adds:
- a width parameter;
- shift, XOR/NOR, and signed and unsigned compare operations;
- iterative multiply, divide and remainder;
- a start/valid handshake and registered status flags.

It sits between the register-file read ports and the writeback mux. The control unit drives it one operation at a time.

## Interface
- LARGURA, 8: operand/result width in bits, ≥ 4, power of two.
- clock  in  1  single clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- inicio  in  1  start request; sampled only when ocupado = 0
- sinal_ula  in  4  operation code
- entrada1  in  LARGURA  operand A / dividend
- entrada2  in  LARGURA  operand B / divisor / shift amount
- saida_ula  out  LARGURA  registered result; holds until the next result
- valido  out  1  one-cycle pulse: saida_ula and flags updated
- ocupado  out  1  multi-cycle operation in progress
- zero, negativo, carry, overflow  out  1 each  registered flags
- div_zero  out  1  last div/rem had divisor 0

## Operation
- Opcodes:
  - 0000 and, 0001 or, 0010 add, 0011 sub
  - 0100 slt (signed), 0101 sltu, 0110 nor, 0111 xor
  - 1000 sll, 1001 srl, 1010 sra
  - 1011 mul (low half), 1100 divu (quotient), 1101 remu
  - 1110/1111: result 0, all flags 0.
- Shift amount = entrada2[log2(LARGURA)-1:0]; upper bits are ignored.
- slt/sltu: result is 1 or 0, zero-extended.
- zero = (result == 0); negativo = result MSB.
- carry:
  - add: carry-out.
  - sub: borrow, i.e. entrada1 < entrada2 unsigned.
  - mul: upper half of the 2·LARGURA-bit product ≠ 0.
  - All other opcodes: 0.
- overflow is the signed overflow for add/sub; 0 for all other opcodes.
- Divide by zero, no iteration: quotient = all ones, remainder = dividend, div_zero = 1, single-cycle latency. div_zero is 0 for all other results.
- FSM states:
  - OCIOSO → MUL on inicio with mul; OCIOSO → DIV on inicio with divu/remu and divisor ≠ 0.
  - MUL/DIV → OCIOSO after LARGURA iterations.
  - Single-cycle opcodes stay in OCIOSO.
- Operands and opcode are latched on acceptance. Input changes during MUL/DIV have no effect.
- mul: shift-add, one partial product per cycle, 2·LARGURA-bit accumulator.
- divu/remu: restoring division, one quotient bit per cycle.
- ocupado = (state ≠ OCIOSO).

## Timing
- Reset (async assert, sync release): saida_ula = 0, all flags 0, valido = 0, ocupado = 0, state OCIOSO.
- Call the edge that samples inicio edge 0.
- Single-cycle ops: result and flags registered at edge 0; valido high for the following cycle.
- mul/divu/remu: ocupado high from edge 0. Iterations run on edges 1..LARGURA, so latency = LARGURA edges.
  - Result, flags and valido update at edge LARGURA.
  - ocupado drops at that same edge.
- Back-to-back: inicio during the valido cycle is accepted. Single-cycle ops sustain one result per cycle.
- inicio while ocupado = 1 is ignored: no queueing, no error.
- Reset mid-operation aborts the operation: no valido, outputs return to reset values.
- valido is never high for more than one cycle per accepted operation.

## Structure
- Package ula_pkg holds:
  - opcode localparams, e.g. OP_AND…OP_REMU;
  - state enum {OCIOSO, MUL, DIV};
  - a helper function for the shift-amount width, $clog2(LARGURA).
- Sub-module ula_muldiv: iterative multiply/divide datapath.
  - It has load/step controls and its own iteration counter, and signals fim.
  - The top level holds the FSM, the single-cycle ops, and the flag/result registers.

## Test plan
(LARGURA = 8)
- Reset then add 200+100 → saida_ula = 44, carry = 1, overflow = 0; valido exactly one cycle after inicio.
- sub 5−7 → 254, negativo = 1, carry = 1, overflow = 0. sub 0x80−0x01 → 0x7F, overflow = 1.
- slt 0x80,0x01 → 1; sltu 0x80,0x01 → 0; sra 0x90 by 2 → 0xE4; sll 0x01 by 0x0F → 0x80 (amount masked to 7).
- mul 13×11 → 143, carry = 0, valido 8 edges after inicio, ocupado high throughout. mul 20×20 → 144, carry = 1. An inicio issued mid-mul is ignored.
- divu 200/7 → 28 and remu 200/7 → 4, each 8-edge latency. divu 9/0 → 255 and remu 9/0 → 9, each with div_zero = 1 and 1-edge latency.
- reset_n low at edge 3 of a mul → no valido, saida_ula = 0, ocupado = 0. A following add 1+1 → 2 normally.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, control states and
// the shift-amount width helper.
package ula_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_SLT  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_NOR  = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1011;
   localparam logic [3:0] OP_DIVU = 4'b1100;
   localparam logic [3:0] OP_REMU = 4'b1101;

   typedef enum logic [1:0] {OCIOSO, MUL, DIV} estado_t;

   function automatic int larg_desloc(input int largura);
      return $clog2(largura);
   endfunction

endpackage

// File: rtl/ula_muldiv.sv
// Iterative datapath: shift-add multiply and restoring divide, one step per
// cycle, with a down-counter that flags the final step.
module ula_muldiv
   import ula_pkg::*;
#(
   parameter int LARGURA = 8
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   carregar,
   input  logic                   passo,
   input  logic [LARGURA-1:0]     op_a,
   input  logic [LARGURA-1:0]     op_b,
   output logic                   fim,
   output logic [2*LARGURA-1:0]   produto_prox,
   output logic [LARGURA-1:0]     quoc_prox,
   output logic [LARGURA-1:0]     resto_prox
);

   localparam int CW = larg_desloc(LARGURA);

   logic [2*LARGURA-1:0] acc;
   logic [2*LARGURA-1:0] mcand;
   logic [LARGURA-1:0]   mplier;
   logic [LARGURA-1:0]   quoc;
   logic [LARGURA-1:0]   resto;
   logic [LARGURA-1:0]   divisor;
   logic [CW-1:0]        cnt;
   logic [LARGURA:0]     parcial;
   logic [LARGURA:0]     dif;

   // Outputs are the values after the current step, so the top can capture
   // the final result on the same edge the last step executes.
   always_comb begin
      produto_prox = acc + (mplier[0] ? mcand : '0);
      parcial      = {resto, quoc[LARGURA-1]};
      dif          = parcial - {1'b0, divisor};
      if (!dif[LARGURA]) begin
         resto_prox = dif[LARGURA-1:0];
         quoc_prox  = {quoc[LARGURA-2:0], 1'b1};
      end else begin
         resto_prox = parcial[LARGURA-1:0];
         quoc_prox  = {quoc[LARGURA-2:0], 1'b0};
      end
   end

   assign fim = (cnt == '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         quoc    <= '0;
         resto   <= '0;
         divisor <= '0;
         cnt     <= '0;
      end else if (carregar) begin
         acc     <= '0;
         mcand   <= {{LARGURA{1'b0}}, op_a};
         mplier  <= op_b;
         quoc    <= op_a;
         resto   <= '0;
         divisor <= op_b;
         cnt     <= CW'(LARGURA - 1);
      end else if (passo) begin
         acc    <= produto_prox;
         mcand  <= {mcand[2*LARGURA-2:0], 1'b0};
         mplier <= {1'b0, mplier[LARGURA-1:1]};
         quoc   <= quoc_prox;
         resto  <= resto_prox;
         if (cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: rtl/ula_multiciclo.sv
// Registered ALU with start/valid handshake; single-cycle ops finish at the
// accepting edge, mul/divu/remu take LARGURA further edges.
//
// state  | meaning
// OCIOSO | idle, accepts inicio; single-cycle ops complete here
// MUL    | shift-add multiply iterating
// DIV    | restoring divide iterating (divu or remu)
module ula_multiciclo
   import ula_pkg::*;
#(
   parameter int LARGURA = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               inicio,
   input  logic [3:0]         sinal_ula,
   input  logic [LARGURA-1:0] entrada1,
   input  logic [LARGURA-1:0] entrada2,
   output logic [LARGURA-1:0] saida_ula,
   output logic               valido,
   output logic               ocupado,
   output logic               zero,
   output logic               negativo,
   output logic               carry,
   output logic               overflow,
   output logic               div_zero
);

   localparam int SW = larg_desloc(LARGURA);

   estado_t estado, estado_prox;

   logic                   eh_resto;
   logic                   carregar, passo, fim, carrega_res;
   logic                   c_prox, v_prox, dz_prox, flags_ativos;
   logic [LARGURA-1:0]     res_prox;
   logic [SW-1:0]          desloc;
   logic [LARGURA:0]       soma, dif;
   logic [2*LARGURA-1:0]   produto_prox;
   logic [LARGURA-1:0]     quoc_prox, resto_prox;

   assign desloc  = entrada2[SW-1:0];
   assign soma    = {1'b0, entrada1} + {1'b0, entrada2};
   assign dif     = {1'b0, entrada1} - {1'b0, entrada2};
   assign ocupado = (estado != OCIOSO);

   ula_muldiv #(.LARGURA(LARGURA)) u_muldiv (
      .clock        (clock),
      .reset_n      (reset_n),
      .carregar     (carregar),
      .passo        (passo),
      .op_a         (entrada1),
      .op_b         (entrada2),
      .fim          (fim),
      .produto_prox (produto_prox),
      .quoc_prox    (quoc_prox),
      .resto_prox   (resto_prox)
   );

   always_comb begin
      estado_prox  = estado;
      carregar     = 1'b0;
      passo        = 1'b0;
      carrega_res  = 1'b0;
      res_prox     = '0;
      c_prox       = 1'b0;
      v_prox       = 1'b0;
      dz_prox      = 1'b0;
      flags_ativos = 1'b1;
      case (estado)
         OCIOSO: begin
            if (inicio) begin
               carrega_res = 1'b1;
               case (sinal_ula)
                  OP_AND:  res_prox = entrada1 & entrada2;
                  OP_OR:   res_prox = entrada1 | entrada2;
                  OP_ADD: begin
                     res_prox = soma[LARGURA-1:0];
                     c_prox   = soma[LARGURA];
                     v_prox   = (entrada1[LARGURA-1] == entrada2[LARGURA-1]) &&
                                (soma[LARGURA-1] != entrada1[LARGURA-1]);
                  end
                  OP_SUB: begin
                     res_prox = dif[LARGURA-1:0];
                     c_prox   = dif[LARGURA];
                     v_prox   = (entrada1[LARGURA-1] != entrada2[LARGURA-1]) &&
                                (dif[LARGURA-1] != entrada1[LARGURA-1]);
                  end
                  OP_SLT:  res_prox = {{(LARGURA-1){1'b0}}, $signed(entrada1) < $signed(entrada2)};
                  OP_SLTU: res_prox = {{(LARGURA-1){1'b0}}, entrada1 < entrada2};
                  OP_NOR:  res_prox = ~(entrada1 | entrada2);
                  OP_XOR:  res_prox = entrada1 ^ entrada2;
                  OP_SLL:  res_prox = entrada1 << desloc;
                  OP_SRL:  res_prox = entrada1 >> desloc;
                  OP_SRA:  res_prox = $signed(entrada1) >>> desloc;
                  OP_MUL: begin
                     carrega_res = 1'b0;
                     carregar    = 1'b1;
                     estado_prox = MUL;
                  end
                  OP_DIVU, OP_REMU: begin
                     // Zero divisor resolves immediately instead of iterating.
                     if (entrada2 == '0) begin
                        res_prox = (sinal_ula == OP_DIVU) ? '1 : entrada1;
                        dz_prox  = 1'b1;
                     end else begin
                        carrega_res = 1'b0;
                        carregar    = 1'b1;
                        estado_prox = DIV;
                     end
                  end
                  default: flags_ativos = 1'b0;
               endcase
            end
         end
         MUL: begin
            passo = 1'b1;
            if (fim) begin
               estado_prox = OCIOSO;
               carrega_res = 1'b1;
               res_prox    = produto_prox[LARGURA-1:0];
               c_prox      = |produto_prox[2*LARGURA-1:LARGURA];
            end
         end
         DIV: begin
            passo = 1'b1;
            if (fim) begin
               estado_prox = OCIOSO;
               carrega_res = 1'b1;
               res_prox    = eh_resto ? resto_prox : quoc_prox;
            end
         end
         default: estado_prox = OCIOSO;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado    <= OCIOSO;
         eh_resto  <= 1'b0;
         saida_ula <= '0;
         valido    <= 1'b0;
         zero      <= 1'b0;
         negativo  <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         estado <= estado_prox;
         valido <= carrega_res;
         if (carregar) begin
            eh_resto <= (sinal_ula == OP_REMU);
         end
         if (carrega_res) begin
            saida_ula <= res_prox;
            zero      <= flags_ativos && (res_prox == '0);
            negativo  <= flags_ativos && res_prox[LARGURA-1];
            carry     <= c_prox;
            overflow  <= v_prox;
            div_zero  <= dz_prox;
         end
      end
   end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo (LARGURA = 8): directed vectors push
// expected results; a negedge monitor pops and compares on every valido.
module tb_ula_multiciclo;
   import ula_pkg::*;

   typedef struct {
      logic [7:0] res;
      logic [4:0] flags;   // {zero, negativo, carry, overflow, div_zero}
      int         lat;
      int         t0;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       inicio = 1'b0;
   logic [3:0] sinal_ula = 4'b0;
   logic [7:0] entrada1 = 8'h00;
   logic [7:0] entrada2 = 8'h00;
   logic [7:0] saida_ula;
   logic       valido, ocupado, zero, negativo, carry, overflow, div_zero;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t q[$];

   ula_multiciclo #(.LARGURA(8)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .inicio    (inicio),
      .sinal_ula (sinal_ula),
      .entrada1  (entrada1),
      .entrada2  (entrada2),
      .saida_ula (saida_ula),
      .valido    (valido),
      .ocupado   (ocupado),
      .zero      (zero),
      .negativo  (negativo),
      .carry     (carry),
      .overflow  (overflow),
      .div_zero  (div_zero)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc = cyc + 1;

   task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] want);
      checks = checks + 1;
      if (got !== want) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, got, want, $time);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] res, input logic [4:0] flags, input int lat);
      exp_t e;
      e.res = res; e.flags = flags; e.lat = lat; e.t0 = 0;
      return e;
   endfunction

   // Monitor: every valido must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (valido) begin
         if (q.size() == 0) begin
            chk("spurious_valido", 32'(valido), 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("saida_ula", 32'(saida_ula), 32'(e.res));
            chk("flags", 32'({zero, negativo, carry, overflow, div_zero}), 32'(e.flags));
            chk("latency", 32'(cyc - e.t0), 32'(e.lat));
         end
      end
   end

   task automatic wait_empty();
      for (int i = 0; i < 30 && q.size() != 0; i++) @(posedge clock);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
   endtask

   task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input exp_t e);
      @(negedge clock);
      sinal_ula = op; entrada1 = a; entrada2 = b; inicio = 1'b1;
      e.t0 = cyc + 1;
      q.push_back(e);
   endtask

   task automatic run_curta(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input exp_t e);
      drive(op, a, b, e);
      @(negedge clock);
      inicio = 1'b0;
      wait_empty();
   endtask

   task automatic run_longa(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            input exp_t e, input bit injeta);
      drive(op, a, b, e);
      @(negedge clock);
      inicio = 1'b0;
      for (int i = 1; i < 8; i++) begin
         chk("ocupado_busy", 32'(ocupado), 32'd1);
         if (injeta && i == 3) begin
            inicio = 1'b1; sinal_ula = OP_ADD; entrada1 = 8'h01; entrada2 = 8'h01;
         end else begin
            inicio = 1'b0;
         end
         @(negedge clock);
      end
      inicio = 1'b0;
      wait_empty();
   endtask

   initial begin
      repeat (2) @(negedge clock);
      chk("reset_outputs",
          32'({saida_ula, valido, ocupado, zero, negativo, carry, overflow, div_zero}), 32'd0);
      reset_n = 1'b1;

      //         res     z n c v dz   lat
      run_curta(OP_ADD,  8'd200, 8'd100, mk(8'd44,  5'b00100, 0));
      run_curta(OP_SUB,  8'd5,   8'd7,   mk(8'd254, 5'b01100, 0));
      run_curta(OP_SUB,  8'h80,  8'h01,  mk(8'h7F,  5'b00010, 0));
      run_curta(OP_SLT,  8'h80,  8'h01,  mk(8'h01,  5'b00000, 0));
      run_curta(OP_SLTU, 8'h80,  8'h01,  mk(8'h00,  5'b10000, 0));
      run_curta(OP_SRA,  8'h90,  8'h02,  mk(8'hE4,  5'b01000, 0));
      run_curta(OP_SLL,  8'h01,  8'h0F,  mk(8'h80,  5'b01000, 0));
      run_curta(OP_SRL,  8'h90,  8'h04,  mk(8'h09,  5'b00000, 0));
      run_curta(OP_NOR,  8'h0F,  8'hF0,  mk(8'h00,  5'b10000, 0));
      run_curta(4'b1110, 8'hFF,  8'hFF,  mk(8'h00,  5'b00000, 0));

      // Back-to-back single-cycle ops, one accepted per cycle.
      drive(OP_AND, 8'hF0, 8'h3C, mk(8'h30, 5'b00000, 0));
      drive(OP_OR,  8'hF0, 8'h0F, mk(8'hFF, 5'b01000, 0));
      drive(OP_XOR, 8'hAA, 8'hFF, mk(8'h55, 5'b00000, 0));
      @(negedge clock);
      inicio = 1'b0;
      wait_empty();

      run_longa(OP_MUL,  8'd13,  8'd11, mk(8'd143, 5'b01000, 8), 1'b0);
      run_longa(OP_MUL,  8'd20,  8'd20, mk(8'd144, 5'b01100, 8), 1'b1);
      run_longa(OP_DIVU, 8'd200, 8'd7,  mk(8'd28,  5'b00000, 8), 1'b0);
      run_longa(OP_REMU, 8'd200, 8'd7,  mk(8'd4,   5'b00000, 8), 1'b1);
      run_curta(OP_DIVU, 8'd9,   8'd0,  mk(8'd255, 5'b01001, 0));
      run_curta(OP_REMU, 8'd9,   8'd0,  mk(8'd9,   5'b00001, 0));

      // Reset asserted just before edge 3 of a multiply aborts it.
      @(negedge clock);
      sinal_ula = OP_MUL; entrada1 = 8'd13; entrada2 = 8'd11; inicio = 1'b1;
      @(negedge clock);
      inicio = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("abort_saida", 32'(saida_ula), 32'd0);
      chk("abort_ocupado", 32'(ocupado), 32'd0);
      chk("abort_valido", 32'(valido), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (12) @(negedge clock);
      run_curta(OP_ADD, 8'd1, 8'd1, mk(8'd2, 5'b00000, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
